// File: rtl/rv32e_run_supervisor_pkg.sv
// ---------------------------------------------------------------------------
// rv32e_run_supervisor_pkg
//   Shared definitions for the rv32e run supervisor:
//     - state_e           : supervisor FSM encoding (S_HOLD / S_RUN / S_DONE)
//     - RV32E_HALT_INSN   : the "jal x0,0" self-loop word used as the halt idiom
//     - DEF_RESET_CYCLES  : default cpu_reset hold length
//     - DEF_TIMEOUT_CYCLES: default run budget
//     - rotl1_xor()       : one step of the control-flow signature accumulator
// ---------------------------------------------------------------------------
package rv32e_run_supervisor_pkg;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [31:0] RV32E_HALT_INSN    = 32'h0000_006F;
    localparam int          DEF_RESET_CYCLES   = 4;
    localparam int          DEF_TIMEOUT_CYCLES = 1024;

    // Rotate left by one, then fold in the new value.
    function automatic logic [31:0] rotl1_xor(input logic [31:0] acc,
                                              input logic [31:0] val);
        return {acc[30:0], acc[31]} ^ val;
    endfunction

endpackage

// File: rtl/rv32e_sig_accum.sv
// ---------------------------------------------------------------------------
// rv32e_sig_accum
//   Rotate-xor accumulator producing a control-flow fingerprint of the fetch
//   address stream. Only instantiated by rv32e_run_supervisor when
//   RV32E_SUPERVISOR_SIGNATURE_EN is defined.
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   async active-low reset, clears the accumulator
//   clear      in   1   sync clear (highest priority)
//   enable     in   1   fold addr into the accumulator this cycle
//   freeze     in   1   hold the accumulator regardless of enable
//   addr       in   32  value folded in
//   signature  out  32  registered accumulator value
// ---------------------------------------------------------------------------
module rv32e_sig_accum
    import rv32e_run_supervisor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        freeze,
    input  logic [31:0] addr,
    output logic [31:0] signature
);

    logic [31:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable && !freeze) begin
            sig_d = rotl1_xor(sig_q, addr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/rv32e_run_supervisor.sv
// ---------------------------------------------------------------------------
// rv32e_run_supervisor
//   Run controller for rv32e_cpu: sequences the CPU reset, watches the program
//   bus for the jal x0,0 halt idiom, enforces a cycle budget and reports
//   done / pass / timeout so a program image can run unattended.
// Ports
//   clk                   in   1       system clock, rising edge
//   reset                 in   1       async active-low reset
//   restart               in   1       sync pulse: abort run, start a new one
//   mem_program_addr_bus  in   ADDR_W  CPU fetch address (monitored)
//   mem_program_data_bus  in   DATA_W  fetched instruction (monitored)
//   cpu_reset             out  1       active-low reset to rv32e_cpu
//   done                  out  1       run finished; sticky until restart/reset
//   pass                  out  1       halted at PASS_ADDR (valid with done)
//   timeout               out  1       budget expired without halt
//   cycle_count           out  CNT_W   run cycles since cpu_reset released
//   signature             out  32      fetch-address fingerprint (macro only)
// Configuration
//   RV32E_SUPERVISOR_SIGNATURE_EN : adds the signature output and accumulator.
// ---------------------------------------------------------------------------
module rv32e_run_supervisor
    import rv32e_run_supervisor_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int                TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int                HALT_REPEAT    = 3,
    parameter logic [DATA_W-1:0] HALT_INSN      = DATA_W'(RV32E_HALT_INSN),
    parameter logic [ADDR_W-1:0] PASS_ADDR      = '0,
    parameter int                CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic [ADDR_W-1:0] mem_program_addr_bus,
    input  logic [DATA_W-1:0] mem_program_data_bus,
    output logic              cpu_reset,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
`ifdef RV32E_SUPERVISOR_SIGNATURE_EN
    ,
    output logic [31:0]       signature
`endif
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int HALT_W = $clog2(HALT_REPEAT + 1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [HALT_W-1:0]   halt_cnt_q, halt_cnt_d;
    logic [ADDR_W-1:0]   prev_addr_q, prev_addr_d;
    logic                prev_vld_q, prev_vld_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;

    logic halt_qual, halt_hit, timeout_hit;

    // A fetch only qualifies when the previous run cycle fetched the same
    // address; prev_vld keeps the first run cycle from comparing against
    // whatever the bus showed while the CPU was still in reset.
    assign halt_qual   = prev_vld_q
                      && (mem_program_addr_bus == prev_addr_q)
                      && (mem_program_data_bus == HALT_INSN);
    assign halt_hit    = halt_qual && (halt_cnt_q == HALT_W'(HALT_REPEAT - 1));
    assign timeout_hit = (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // NOTE: every signal is given its hold value first so no path through the
    // case statement leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        halt_cnt_d    = halt_cnt_q;
        prev_addr_d   = prev_addr_q;
        prev_vld_d    = prev_vld_q;
        cpu_reset_d   = cpu_reset_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        cycle_count_d = cycle_count_q;

        if (restart) begin
            // Restart overrides everything, including a same-cycle halt/timeout.
            state_d       = S_HOLD;
            hold_cnt_d    = '0;
            halt_cnt_d    = '0;
            prev_addr_d   = '0;
            prev_vld_d    = 1'b0;
            cpu_reset_d   = 1'b0;
            done_d        = 1'b0;
            pass_d        = 1'b0;
            timeout_d     = 1'b0;
            cycle_count_d = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    cpu_reset_d = 1'b0;
                    if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
                        state_d     = S_RUN;
                        hold_cnt_d  = '0;
                        cpu_reset_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    prev_addr_d   = mem_program_addr_bus;
                    prev_vld_d    = 1'b1;
                    halt_cnt_d    = halt_qual ? halt_cnt_q + HALT_W'(1) : '0;
                    // Saturate so the count never wraps past its terminal value.
                    cycle_count_d = timeout_hit ? cycle_count_q
                                                : cycle_count_q + CNT_W'(1);
                    if (halt_hit) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        pass_d    = (mem_program_addr_bus == PASS_ADDR);
                        timeout_d = 1'b0;
                    end else if (timeout_hit) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        timeout_d   = 1'b1;
                        pass_d      = 1'b0;
                        cpu_reset_d = 1'b0;
                    end
                end
                S_DONE: begin
                    // Everything holds until restart or reset.
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            halt_cnt_q    <= '0;
            prev_addr_q   <= '0;
            prev_vld_q    <= 1'b0;
            cpu_reset_q   <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            halt_cnt_q    <= halt_cnt_d;
            prev_addr_q   <= prev_addr_d;
            prev_vld_q    <= prev_vld_d;
            cpu_reset_q   <= cpu_reset_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;

`ifdef RV32E_SUPERVISOR_SIGNATURE_EN
    logic [31:0] sig_addr;

    if (ADDR_W >= 32) begin : g_addr_trunc
        assign sig_addr = mem_program_addr_bus[31:0];
    end else begin : g_addr_zext
        assign sig_addr = {{(32 - ADDR_W){1'b0}}, mem_program_addr_bus};
    end

    rv32e_sig_accum u_sig_accum (
        .clk       (clk),
        .reset     (reset),
        .clear     (restart),
        .enable    (state_q == S_RUN),
        .freeze    (state_q == S_DONE),
        .addr      (sig_addr),
        .signature (signature)
    );
`endif

endmodule

// File: tb/tb_rv32e_run_supervisor.sv
// ---------------------------------------------------------------------------
// tb_rv32e_run_supervisor
//   Self-checking bench for rv32e_run_supervisor. The bench plays the role of
//   the CPU/ROM by driving one fetch per run cycle from a program table; a
//   reference model walks the same table and predicts when and how the run
//   ends (halt streak, pass address, timeout, frozen count, signature).
// ---------------------------------------------------------------------------
module tb_rv32e_run_supervisor;

    localparam int          ADDR_W         = 32;
    localparam int          DATA_W         = 32;
    localparam int          RESET_CYCLES   = 4;
    localparam int          TIMEOUT_CYCLES = 50;
    localparam int          HALT_REPEAT    = 3;
    localparam int          CNT_W          = 16;
    localparam logic [31:0] HALT           = 32'h0000_006F;
    localparam logic [31:0] NOP            = 32'h0000_0013;
    localparam logic [31:0] PASS_ADDR      = 32'h0000_0010;
    localparam int          MAXLEN         = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              restart;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              cpu_reset;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;
`ifdef RV32E_SUPERVISOR_SIGNATURE_EN
    logic [31:0]       signature;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32e_run_supervisor #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .RESET_CYCLES   (RESET_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .HALT_REPEAT    (HALT_REPEAT),
        .HALT_INSN      (HALT),
        .PASS_ADDR      (PASS_ADDR),
        .CNT_W          (CNT_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .restart              (restart),
        .mem_program_addr_bus (addr),
        .mem_program_data_bus (data),
        .cpu_reset            (cpu_reset),
        .done                 (done),
        .pass                 (pass),
        .timeout              (timeout),
        .cycle_count          (cycle_count)
`ifdef RV32E_SUPERVISOR_SIGNATURE_EN
        ,
        .signature            (signature)
`endif
    );

    // Program table: fetch presented on each run cycle.
    logic [31:0] p_addr [MAXLEN];
    logic [31:0] p_data [MAXLEN];

    // Model predictions for the current table.
    int          exp_term;
    logic        exp_pass;
    logic        exp_timeout;
    int          exp_count;
    logic [31:0] exp_sig;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the program: a run cycle i continues a halt streak when it repeats
    // the previous run cycle's address with the halt word. The run ends at the
    // first cycle where the streak reaches HALT_REPEAT, or at run cycle
    // TIMEOUT_CYCLES-1 (halt has priority on that cycle).
    task automatic model_run();
        int streak;
        streak      = 0;
        exp_term    = TIMEOUT_CYCLES - 1;
        exp_pass    = 1'b0;
        exp_timeout = 1'b1;
        exp_count   = TIMEOUT_CYCLES - 1;
        exp_sig     = '0;
        for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
            exp_sig = {exp_sig[30:0], exp_sig[31]} ^ p_addr[i];
            if (i > 0 && p_addr[i] == p_addr[i-1] && p_data[i] == HALT) streak++;
            else streak = 0;
            if (streak == HALT_REPEAT) begin
                exp_term    = i;
                exp_pass    = (p_addr[i] == PASS_ADDR);
                exp_timeout = 1'b0;
                exp_count   = (i + 1 < TIMEOUT_CYCLES - 1) ? i + 1 : TIMEOUT_CYCLES - 1;
                return;
            end
        end
    endtask

    // Straight-line code from 0x100 for 'prefix' cycles, then jal x0,0 at loop_addr.
    task automatic fill_loop(input int prefix, input logic [31:0] loop_addr);
        for (int i = 0; i < MAXLEN; i++) begin
            if (i < prefix) begin
                p_addr[i] = 32'h100 + 32'(4 * i);
                p_data[i] = $urandom;
                if (p_data[i] == HALT) p_data[i] = NOP;
            end else begin
                p_addr[i] = loop_addr;
                p_data[i] = HALT;
            end
        end
    endtask

    // Small address range and sprinkled halt words so partial streaks occur.
    task automatic fill_random();
        int plen;
        logic [31:0] la;
        plen = $urandom_range(0, 52);
        la   = ($urandom_range(0, 1) == 1) ? PASS_ADDR : (32'($urandom_range(0, 15)) << 2);
        for (int i = 0; i < MAXLEN; i++) begin
            if (i < plen) begin
                p_addr[i] = 32'($urandom_range(0, 7)) << 2;
                p_data[i] = ($urandom_range(0, 3) == 0) ? HALT : NOP;
            end else begin
                p_addr[i] = la;
                p_data[i] = HALT;
            end
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // cpu_reset must stay low for exactly RESET_CYCLES edges, then rise.
    task automatic check_hold(input string tag);
        for (int k = 0; k < RESET_CYCLES; k++) begin
            addr = $urandom;
            data = $urandom;
            check($sformatf("%s_hold_cpu_reset_%0d", tag, k), cpu_reset, 1'b0);
            check($sformatf("%s_hold_done_%0d", tag, k), done, 1'b0);
            tick();
        end
        check($sformatf("%s_cpu_reset_released", tag), cpu_reset, 1'b1);
        check($sformatf("%s_count_start", tag), cycle_count, 0);
    endtask

    task automatic drive_run(input string tag);
        for (int i = 0; i <= exp_term; i++) begin
            addr = p_addr[i];
            data = p_data[i];
            tick();
            check($sformatf("%s_done_c%0d", tag, i), done, (i == exp_term));
            if (i < exp_term) check($sformatf("%s_count_c%0d", tag, i), cycle_count, i + 1);
        end
        check($sformatf("%s_pass", tag), pass, exp_pass);
        check($sformatf("%s_timeout", tag), timeout, exp_timeout);
        check($sformatf("%s_count_final", tag), cycle_count, exp_count);
        check($sformatf("%s_cpu_reset_final", tag), cpu_reset, !exp_timeout);
`ifdef RV32E_SUPERVISOR_SIGNATURE_EN
        check($sformatf("%s_signature", tag), signature, exp_sig);
`endif
        for (int k = 0; k < 3; k++) begin
            addr = ($urandom_range(0, 1) == 1) ? PASS_ADDR : $urandom;
            data = ($urandom_range(0, 1) == 1) ? HALT : $urandom;
            tick();
        end
        check($sformatf("%s_frozen_done", tag), done, 1'b1);
        check($sformatf("%s_frozen_pass", tag), pass, exp_pass);
        check($sformatf("%s_frozen_timeout", tag), timeout, exp_timeout);
        check($sformatf("%s_frozen_count", tag), cycle_count, exp_count);
        check($sformatf("%s_frozen_cpu_reset", tag), cpu_reset, !exp_timeout);
`ifdef RV32E_SUPERVISOR_SIGNATURE_EN
        check($sformatf("%s_frozen_signature", tag), signature, exp_sig);
`endif
    endtask

    task automatic run_program(input string tag, input bit do_restart);
        model_run();
        if (do_restart) pulse_restart();
        check_hold(tag);
        drive_run(tag);
    endtask

    task automatic check_cleared(input string tag);
        check($sformatf("%s_cpu_reset", tag), cpu_reset, 1'b0);
        check($sformatf("%s_done", tag), done, 1'b0);
        check($sformatf("%s_pass", tag), pass, 1'b0);
        check($sformatf("%s_timeout", tag), timeout, 1'b0);
        check($sformatf("%s_count", tag), cycle_count, 0);
`ifdef RV32E_SUPERVISOR_SIGNATURE_EN
        check($sformatf("%s_signature", tag), signature, 0);
`endif
    endtask

    initial begin
        reset   = 1'b1;
        restart = 1'b0;
        addr    = '0;
        data    = '0;
        #2 reset = 1'b0;
        #1;
        check_cleared("reset_async");
        tick();
        tick();
        check_cleared("reset_held");
        reset = 1'b1;

        // Reset release sequence, then a loop at the pass address.
        fill_loop(4, PASS_ADDR);
        run_program("pass_loop", 1'b0);

        // Same idiom away from the pass address.
        fill_loop(7, 32'h20);
        run_program("fail_loop", 1'b1);

        // Never halts: straight-line code for the whole budget.
        fill_loop(MAXLEN, PASS_ADDR);
        run_program("timeout_run", 1'b1);

        // Loop at the right address but the wrong instruction word.
        fill_loop(3, PASS_ADDR);
        for (int i = 3; i < MAXLEN; i++) p_data[i] = NOP;
        run_program("wrong_insn", 1'b1);

        // Halt streak completes exactly on the timeout cycle: halt wins.
        fill_loop(TIMEOUT_CYCLES - HALT_REPEAT - 1, PASS_ADDR);
        run_program("halt_vs_timeout", 1'b1);

        // Loop from the very first run cycle.
        fill_loop(0, PASS_ADDR);
        run_program("loop_at_start", 1'b1);

        // Addresses 0,4,8 then halt at 8.
        fill_loop(2, 32'h8);
        p_addr[0] = 32'h0;
        p_addr[1] = 32'h4;
        run_program("sig_directed", 1'b1);

        // Restart pulse mid-run: full hold sequence repeats, then a clean run.
        fill_loop(10, PASS_ADDR);
        model_run();
        pulse_restart();
        check_hold("restart_mid_pre");
        for (int i = 0; i < 6; i++) begin
            addr = p_addr[i];
            data = p_data[i];
            tick();
        end
        addr = p_addr[6];
        data = p_data[6];
        pulse_restart();
        check_cleared("restart_mid");
        check_hold("restart_mid_post");
        drive_run("restart_mid_run");

        // Restart on the very edge the halt would be detected.
        fill_loop(5, PASS_ADDR);
        model_run();
        pulse_restart();
        check_hold("restart_halt_pre");
        for (int i = 0; i < exp_term; i++) begin
            addr = p_addr[i];
            data = p_data[i];
            tick();
        end
        addr = p_addr[exp_term];
        data = p_data[exp_term];
        pulse_restart();
        check_cleared("restart_halt_edge");
        check_hold("restart_halt_post");
        drive_run("restart_halt_run");

        // Restart held high keeps the block parked in hold.
        fill_random();
        model_run();
        restart = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check_cleared("restart_held");
        restart = 1'b0;
        check_hold("restart_held_post");
        drive_run("restart_held_run");

        // Async reset mid-run, between clock edges.
        fill_loop(MAXLEN, PASS_ADDR);
        model_run();
        pulse_restart();
        check_hold("areset_pre");
        for (int i = 0; i < 20; i++) begin
            addr = p_addr[i];
            data = p_data[i];
            tick();
        end
        #3 reset = 1'b0;
        #1;
        check_cleared("areset_mid_run");
        tick();
        reset = 1'b1;
        check_hold("areset_post");
        drive_run("areset_run");

        // Randomized programs.
        for (int r = 0; r < 10; r++) begin
            fill_random();
            run_program($sformatf("random%0d", r), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
